// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/IO single-port memory arbiter:
// FSM state encoding, requester id constants and the tie-break helper.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      REJECT = 2'd3
   } state_t;

   localparam logic CPU = 1'b0;
   localparam logic IO  = 1'b1;

   // Choose the winning requester. A lone requester always wins; when both
   // request, the port named by prio (the one that did not win last) wins.
   function automatic logic pick_winner(input logic cpu_req,
                                        input logic io_req,
                                        input logic prio);
      logic w;
      if (cpu_req && io_req) begin
         w = prio;
      end else if (io_req) begin
         w = IO;
      end else begin
         w = CPU;
      end
      return w;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU, IO) arbiter in front of a single-port synchronous RAM.
// One transaction at a time: a request is latched in IDLE, the RAM is
// accessed for one cycle, and reads return data in the following cycle.
// IO writes into the protected low region are refused with io_err.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int                WIDTH    = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] PROT_TOP = 16'h00FF
) (
   input  logic              clk,
   input  logic              reset,
   // CPU requester
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WIDTH-1:0]  cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [WIDTH-1:0]  cpu_rdata,
   // IO requester
   input  logic              io_req,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [WIDTH-1:0]  io_wdata,
   output logic              io_gnt,
   output logic              io_rvalid,
   output logic [WIDTH-1:0]  io_rdata,
   output logic              io_err,
   // single-port RAM
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_prio;      // port that wins the next tie
   logic                r_winner;    // port owning the current transaction
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [WIDTH-1:0]    r_wdata;

   logic                w_any_req;
   logic                w_pick;
   logic                w_reject;
   logic                w_latch;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [WIDTH-1:0]    w_sel_wdata;

   // Arbitration: pick the winner and its request fields, flag protected IO writes.
   always_comb begin
      w_any_req   = cpu_req | io_req;
      w_pick      = pick_winner(cpu_req, io_req, r_prio);
      w_sel_we    = (w_pick == IO) ? io_we    : cpu_we;
      w_sel_addr  = (w_pick == IO) ? io_addr  : cpu_addr;
      w_sel_wdata = (w_pick == IO) ? io_wdata : cpu_wdata;
      w_reject    = (w_pick == IO) && io_we && (io_addr <= PROT_TOP);
      w_latch     = (r_state == IDLE) && w_any_req;
   end

   // State register, round-robin pointer and latched request fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_prio   <= CPU;
         r_winner <= CPU;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_winner <= w_pick;
            r_prio   <= ~w_pick;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
         end
      end
   end

   // Next-state and output decode from state and winner id; all outputs held low in reset.
   always_comb begin
      w_state_nxt = r_state;
      cpu_gnt     = 1'b0;
      cpu_rvalid  = 1'b0;
      cpu_rdata   = '0;
      io_gnt      = 1'b0;
      io_rvalid   = 1'b0;
      io_rdata    = '0;
      io_err      = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;

      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_nxt = w_reject ? REJECT : ACCESS;
            end
         end
         ACCESS: begin
            w_state_nxt = r_we ? IDLE : RESP;
            if (!reset) begin
               mem_en    = 1'b1;
               mem_we    = r_we;
               mem_addr  = r_addr;
               mem_wdata = r_wdata;
               cpu_gnt   = (r_winner == CPU);
               io_gnt    = (r_winner == IO);
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
            if (!reset) begin
               if (r_winner == IO) begin
                  io_rvalid = 1'b1;
                  io_rdata  = mem_rdata;
               end else begin
                  cpu_rvalid = 1'b1;
                  cpu_rdata  = mem_rdata;
               end
            end
         end
         REJECT: begin
            w_state_nxt = IDLE;
            if (!reset) begin
               io_gnt = 1'b1;
               io_err = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected output
// cycles into a queue, a negedge monitor pops and compares whenever the
// arbiter shows activity and otherwise expects every output at zero.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_gnt, cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        io_req = 1'b0, io_we = 1'b0;
   logic [15:0] io_addr = '0, io_wdata = '0;
   logic        io_gnt, io_rvalid, io_err;
   logic [15:0] io_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   mem_arbiter #(.WIDTH(16), .ADDR_W(16), .PROT_TOP(16'h00FF)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata), .io_err(io_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // single-port synchronous RAM model
   logic [15:0] ram [0:65535];
   logic [15:0] ram_q = '0;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         ram_q <= ram[mem_addr];
      end
   end
   assign mem_rdata = ram_q;

   typedef struct packed {
      logic        cg, ig, cr, ir, err, en, we;
      logic [15:0] addr, wdata, crd, ird;
   } ev_t;

   ev_t q[$];
   int  n_vec = 0;
   int  n_err = 0;

   function automatic ev_t ev_acc(input logic port, input logic we,
                                  input logic [15:0] a, input logic [15:0] d);
      ev_t e = '0;
      e.cg = (port == CPU); e.ig = (port == IO);
      e.en = 1'b1; e.we = we; e.addr = a; e.wdata = d;
      return e;
   endfunction

   function automatic ev_t ev_rsp(input logic port, input logic [15:0] d);
      ev_t e = '0;
      if (port == CPU) begin e.cr = 1'b1; e.crd = d; end
      else             begin e.ir = 1'b1; e.ird = d; end
      return e;
   endfunction

   function automatic ev_t ev_rej();
      ev_t e = '0;
      e.ig = 1'b1; e.err = 1'b1;
      return e;
   endfunction

   // monitor: compare every cycle, away from the active edge
   always @(negedge clk) begin
      ev_t obs, exp_e;
      obs.cg = cpu_gnt;  obs.ig = io_gnt;  obs.cr = cpu_rvalid; obs.ir = io_rvalid;
      obs.err = io_err;  obs.en = mem_en;  obs.we = mem_we;
      obs.addr = mem_addr; obs.wdata = mem_wdata; obs.crd = cpu_rdata; obs.ird = io_rdata;
      n_vec++;
      if (reset || !(cpu_gnt | io_gnt | cpu_rvalid | io_rvalid | io_err | mem_en)) begin
         if (obs != '0) begin
            n_err++;
            $display("FAIL quiet_cycle t=%0t got=%h exp=0", $time, obs);
         end
      end else if (q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_activity t=%0t got=%h exp=none", $time, obs);
      end else begin
         exp_e = q.pop_front();
         if (obs != exp_e) begin
            n_err++;
            $display("FAIL event t=%0t got=%h exp=%h", $time, obs, exp_e);
         end
      end
   end

   task automatic req_start(input logic port, input logic we,
                            input logic [15:0] a, input logic [15:0] d);
      if (port == CPU) begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      else             begin io_req  = 1'b1; io_we  = we; io_addr  = a; io_wdata  = d; end
   endtask

   task automatic req_stop(input logic port);
      if (port == CPU) begin cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; end
      else             begin io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0; end
   endtask

   task automatic single(input logic port, input logic we, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] rd_exp, input logic rej);
      if (rej) q.push_back(ev_rej());
      else begin
         q.push_back(ev_acc(port, we, a, d));
         if (!we) q.push_back(ev_rsp(port, rd_exp));
      end
      req_start(port, we, a, d);
      @(posedge clk); #1;
      req_stop(port);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_ram(input string name, input logic [15:0] a, input logic [15:0] v);
      n_vec++;
      if (ram[a] !== v) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", name, ram[a], v);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
      ram[16'h0123] = 16'hBEEF;
      ram[16'h0040] = 16'h1234;
      ram[16'h0041] = 16'h5678;
      ram[16'h0010] = 16'h1111;
      ram[16'h00FF] = 16'h3333;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // both requesters continuously: CPU, IO, CPU, IO
      q.push_back(ev_acc(CPU, 1'b0, 16'h0040, 16'h0)); q.push_back(ev_rsp(CPU, 16'h1234));
      q.push_back(ev_acc(IO,  1'b0, 16'h0041, 16'h0)); q.push_back(ev_rsp(IO,  16'h5678));
      q.push_back(ev_acc(CPU, 1'b0, 16'h0040, 16'h0)); q.push_back(ev_rsp(CPU, 16'h1234));
      q.push_back(ev_acc(IO,  1'b0, 16'h0041, 16'h0)); q.push_back(ev_rsp(IO,  16'h5678));
      req_start(CPU, 1'b0, 16'h0040, 16'h0);
      req_start(IO,  1'b0, 16'h0041, 16'h0);
      repeat (12) @(posedge clk);
      #1; req_stop(CPU); req_stop(IO);
      repeat (2) @(posedge clk);
      #1;

      // lone CPU read
      single(CPU, 1'b0, 16'h0123, 16'h0, 16'hBEEF, 1'b0);
      // protected IO writes, including the boundary address
      single(IO, 1'b1, 16'h0010, 16'h5555, 16'h0, 1'b1);
      check_ram("reject_0010", 16'h0010, 16'h1111);
      single(IO, 1'b1, 16'h00FF, 16'h7777, 16'h0, 1'b1);
      check_ram("reject_00FF", 16'h00FF, 16'h3333);
      // accepted IO writes with readback
      single(IO, 1'b1, 16'h0200, 16'hA5A5, 16'h0, 1'b0);
      check_ram("write_0200", 16'h0200, 16'hA5A5);
      single(IO, 1'b0, 16'h0200, 16'h0, 16'hA5A5, 1'b0);
      single(IO, 1'b1, 16'h0100, 16'hC3C3, 16'h0, 1'b0);
      single(CPU, 1'b0, 16'h0100, 16'h0, 16'hC3C3, 1'b0);
      // IO reads of the protected region are allowed
      single(IO, 1'b0, 16'h0010, 16'h0, 16'h1111, 1'b0);
      // CPU write, then a tie goes to IO because CPU won last
      single(CPU, 1'b1, 16'h0300, 16'h0F0F, 16'h0, 1'b0);
      q.push_back(ev_acc(IO,  1'b0, 16'h0300, 16'h0)); q.push_back(ev_rsp(IO,  16'h0F0F));
      q.push_back(ev_acc(CPU, 1'b0, 16'h0123, 16'h0)); q.push_back(ev_rsp(CPU, 16'hBEEF));
      req_start(CPU, 1'b0, 16'h0123, 16'h0);
      req_start(IO,  1'b0, 16'h0300, 16'h0);
      repeat (6) @(posedge clk);
      #1; req_stop(CPU); req_stop(IO);
      repeat (2) @(posedge clk);
      #1;

      // reset during the ACCESS cycle of a CPU read: aborted, CPU priority restored
      req_start(CPU, 1'b0, 16'h0040, 16'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      req_stop(CPU);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      q.push_back(ev_acc(CPU, 1'b0, 16'h0040, 16'h0)); q.push_back(ev_rsp(CPU, 16'h1234));
      q.push_back(ev_acc(IO,  1'b0, 16'h0041, 16'h0)); q.push_back(ev_rsp(IO,  16'h5678));
      req_start(CPU, 1'b0, 16'h0040, 16'h0);
      req_start(IO,  1'b0, 16'h0041, 16'h0);
      repeat (6) @(posedge clk);
      #1; req_stop(CPU); req_stop(IO);
      repeat (4) @(posedge clk);
      #1;

      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data width of both ports and memory.
REQ-002 Parameter ADDR_W, default 16, address width.
REQ-003 Parameter PROT_TOP, default 16'h00FF; IO writes to addresses <= PROT_TOP are rejected.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 cpu_req, cpu_we  input  1 each  CPU access request, write enable.
REQ-007 cpu_addr  input  ADDR_W  CPU address; cpu_wdata  input  WIDTH  CPU write data.
REQ-008 cpu_gnt, cpu_rvalid  output  1 each  CPU request accepted; CPU read data valid.
REQ-009 cpu_rdata  output  WIDTH  CPU read data.
REQ-010 io_req, io_we, io_addr, io_wdata, io_gnt, io_rvalid, io_rdata  same directions/widths as the CPU port, for the IO requester.
REQ-011 io_err  output  1  one-cycle pulse: IO write rejected.
REQ-012 mem_en, mem_we  output  1 each  single-port RAM enable, write enable.
REQ-013 mem_addr  output  ADDR_W; mem_wdata  output  WIDTH; mem_rdata  input  WIDTH, valid the cycle after a read with mem_en=1.

Function
REQ-014 FSM states: IDLE, ACCESS, RESP, REJECT.
REQ-015 IDLE: no request -> stay; any request -> latch winner id, addr, we, wdata into internal registers; go to ACCESS.
REQ-016 Both requests in IDLE: winner is the port that did not win last; after reset, CPU wins first.
REQ-017 Single request: that port wins regardless of pointer; pointer updates to the winner.
REQ-018 IDLE, winner IO, io_we=1, io_addr <= PROT_TOP: go to REJECT instead of ACCESS.
REQ-019 ACCESS: mem_en=1, mem_addr/mem_we/mem_wdata from latched registers; winner gnt=1 for this one cycle only.
REQ-020 ACCESS exit: write -> IDLE; read -> RESP.
REQ-021 RESP: winner rvalid=1 for one cycle; winner rdata = mem_rdata; mem_en=0; next IDLE.
REQ-022 REJECT: io_gnt=1 and io_err=1 for one cycle; mem_en=0; next IDLE; pointer updated as for a normal IO win.
REQ-023 Read latency: req sampled in cycle 0 -> gnt cycle 1 -> rvalid cycle 2. Write: gnt cycle 1, arbiter back in IDLE cycle 2.
REQ-024 Requesters hold req and stable addr/we/wdata until gnt; a request dropped before gnt is not served unless already latched.
REQ-025 A request latched in IDLE completes even if req deasserts in ACCESS.
REQ-026 Non-winner outputs: gnt, rvalid = 0; rdata = 0.
REQ-027 mem_addr, mem_wdata = 0 and mem_we = 0 whenever mem_en = 0.
REQ-028 No back-to-back access: at least one IDLE cycle between transactions.

Reset
REQ-029 Reset -> state IDLE, pointer favors CPU, latched registers 0.
REQ-030 During and after reset, all outputs = 0 (gnt, rvalid, rdata, io_err, mem_*).
REQ-031 Reset in ACCESS or RESP aborts the transaction; no rvalid is produced for it.

Structure
REQ-032 A shared package holds the state enum (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2, REJECT=2'd3) and the port-id constants (CPU=1'b0, IO=1'b1).
REQ-033 Single module, no sub-modules; one registered FSM plus latched request registers, outputs decoded from state and winner id.

Verification
REQ-034 CPU read only, addr 16'h0123, RAM holds 16'hBEEF -> cpu_gnt cycle 1; cpu_rvalid cycle 2 with cpu_rdata=16'hBEEF; io_* all 0.
REQ-035 CPU and IO both request continuously after reset -> grants in order CPU, IO, CPU, IO; each grant followed by its rvalid.
REQ-036 IO write addr 16'h0010, data 16'h5555, PROT_TOP=16'h00FF -> io_gnt and io_err in cycle 1, mem_en never 1, RAM unchanged.
REQ-037 IO write addr 16'h0200, data 16'hA5A5 -> mem_en=1, mem_we=1, mem_addr=16'h0200, mem_wdata=16'hA5A5 in cycle 1; readback returns 16'hA5A5.
REQ-038 Reset asserted in the ACCESS cycle of a CPU read -> no cpu_rvalid; IDLE next; the next simultaneous request goes to CPU.
